// File: rtl/tx_frame_conditioner.sv
// tx_frame_conditioner: conditions MAC-bound AXI-Stream frames. Runt frames are
// padded with zero bytes up to MIN_FRAME_BYTES. Frames longer than
// MAX_FRAME_BYTES are cut at the limit and flagged on m_tuser_err. Malformed
// tkeep is flagged too. One registered output stage gives full throughput.
// Optional: define TX_FRAME_STATS_EN to build the per-frame statistics counters;
// without it the stat_* outputs are tied to zero.
module tx_frame_conditioner #(
    parameter int AXI_DATA_WIDTH       = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 512,
    parameter int MIN_FRAME_BYTES      = 60,
    parameter int MAX_FRAME_BYTES      = 1514
) (
    input  logic                            clk156,
    input  logic                            areset_clk156,
    input  logic [AXI_DATA_WIDTH-1:0]       s_tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]     s_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_tuser,
    input  logic                            s_tuser_err,
    input  logic                            s_tvalid,
    input  logic                            s_tlast,
    output logic                            s_tready,
    output logic [AXI_DATA_WIDTH-1:0]       m_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0]     m_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0] m_tuser,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    output logic                            m_tuser_err,
    input  logic                            m_tready,
    output logic [31:0]                     stat_pad_pkts,
    output logic [31:0]                     stat_trunc_pkts,
    output logic [31:0]                     stat_keep_err_pkts
);
    localparam int              KW       = AXI_DATA_WIDTH / 8;
    localparam logic [16:0]     MIN_B    = 17'(MIN_FRAME_BYTES);
    localparam logic [16:0]     MAX_B    = 17'(MAX_FRAME_BYTES);
    localparam logic [16:0]     KW_B     = 17'(KW);
    localparam logic [KW-1:0]   KEEP_ALL = '1;
    localparam logic [KW-1:0]   KEEP_ONE = {{(KW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_PASS = 2'd0, ST_PAD = 2'd1, ST_TRUNC = 2'd2} state_t;

    // tkeep with the lowest n byte lanes set.
    function automatic logic [KW-1:0] low_mask(input logic [16:0] n);
        logic [KW-1:0] m;
        for (int i = 0; i < KW; i++) m[i] = (17'(i) < n);
        return m;
    endfunction

    // Byte counter addition that sticks at 0xFFFF.
    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [16:0] b);
        logic [16:0] s;
        s = {1'b0, c} + b;
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t                          state_q, state_d;
    logic [15:0]                     cnt_q, cnt_d;
    logic                            keep_err_q, keep_err_d;
    logic                            pend_err_q, pend_err_d;
    logic                            rdy_en_q;
    logic                            m_tvalid_q, m_tvalid_d;
    logic                            m_tlast_q, m_tlast_d;
    logic                            m_tuser_err_q, m_tuser_err_d;
    logic [AXI_DATA_WIDTH-1:0]       m_tdata_q, m_tdata_d;
    logic [KW-1:0]                   m_tkeep_q, m_tkeep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;

    logic [AXI_DATA_WIDTH-1:0] data_clean;
    logic [16:0]               beat_bytes;
    logic [KW-1:0]             keep_inc;
    logic                      beat_keep_err;
    logic [16:0]               sum_bytes;
    logic [16:0]               pad_left;
    logic                      frame_err;
    logic                      out_ready;
    logic                      s_tready_c;
    logic                      load_c;
    logic                      tag_pad_c, tag_trunc_c, tag_kerr_c;

    // Null byte lanes are driven as zero so padding extensions are clean.
    generate
        for (genvar gi = 0; gi < KW; gi++) begin : g_clean
            assign data_clean[gi*8 +: 8] = s_tkeep[gi] ? s_tdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // Byte count of the incoming beat and its tkeep sanity (partial non-last beat or holes).
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KW; i++) beat_bytes = beat_bytes + 17'(s_tkeep[i]);
        keep_inc      = s_tkeep + KEEP_ONE;
        beat_keep_err = (!s_tlast && (s_tkeep != KEEP_ALL)) || (|(s_tkeep & keep_inc));
    end

    // Next-state, counter and output-stage load logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        keep_err_d    = keep_err_q;
        pend_err_d    = pend_err_q;
        m_tvalid_d    = m_tvalid_q & ~m_tready;
        m_tdata_d     = m_tdata_q;
        m_tkeep_d     = m_tkeep_q;
        m_tuser_d     = m_tuser_q;
        m_tlast_d     = m_tlast_q;
        m_tuser_err_d = m_tuser_err_q;
        load_c        = 1'b0;
        tag_pad_c     = 1'b0;
        tag_trunc_c   = 1'b0;
        tag_kerr_c    = 1'b0;
        s_tready_c    = 1'b0;
        out_ready     = ~m_tvalid_q | m_tready;
        sum_bytes     = {1'b0, cnt_q} + beat_bytes;
        pad_left      = MIN_B - {1'b0, cnt_q};
        frame_err     = keep_err_q | beat_keep_err;
        case (state_q)
            ST_PASS: begin
                s_tready_c = rdy_en_q & out_ready;
                if (s_tvalid && s_tready_c) begin
                    load_c     = 1'b1;
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = data_clean;
                    m_tuser_d  = s_tuser;
                    tag_kerr_c = frame_err;
                    if (sum_bytes > MAX_B) begin
                        // Over-length wins even when MIN and MAX land on the same beat.
                        m_tkeep_d     = low_mask(MAX_B - {1'b0, cnt_q});
                        m_tlast_d     = 1'b1;
                        m_tuser_err_d = 1'b1;
                        tag_trunc_c   = 1'b1;
                        cnt_d         = '0;
                        keep_err_d    = 1'b0;
                        state_d       = s_tlast ? ST_PASS : ST_TRUNC;
                    end else if (s_tlast && sum_bytes < MIN_B) begin
                        tag_pad_c = 1'b1;
                        if (pad_left <= KW_B) begin
                            m_tkeep_d     = low_mask(pad_left);
                            m_tlast_d     = 1'b1;
                            m_tuser_err_d = s_tuser_err | frame_err;
                            cnt_d         = '0;
                            keep_err_d    = 1'b0;
                        end else begin
                            m_tkeep_d     = KEEP_ALL;
                            m_tlast_d     = 1'b0;
                            m_tuser_err_d = 1'b0;
                            cnt_d         = sat_add(cnt_q, KW_B);
                            keep_err_d    = frame_err;
                            pend_err_d    = s_tuser_err;
                            state_d       = ST_PAD;
                        end
                    end else begin
                        m_tkeep_d = s_tkeep;
                        m_tlast_d = s_tlast;
                        if (s_tlast) begin
                            m_tuser_err_d = s_tuser_err | frame_err;
                            cnt_d         = '0;
                            keep_err_d    = 1'b0;
                        end else begin
                            m_tuser_err_d = 1'b0;
                            cnt_d         = sat_add(cnt_q, beat_bytes);
                            keep_err_d    = frame_err;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (out_ready) begin
                    // Zero filler beats; m_tuser keeps the last accepted value.
                    load_c     = 1'b1;
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = '0;
                    tag_pad_c  = 1'b1;
                    tag_kerr_c = keep_err_q;
                    if (pad_left <= KW_B) begin
                        m_tkeep_d     = low_mask(pad_left);
                        m_tlast_d     = 1'b1;
                        m_tuser_err_d = pend_err_q | keep_err_q;
                        cnt_d         = '0;
                        keep_err_d    = 1'b0;
                        pend_err_d    = 1'b0;
                        state_d       = ST_PASS;
                    end else begin
                        m_tkeep_d     = KEEP_ALL;
                        m_tlast_d     = 1'b0;
                        m_tuser_err_d = 1'b0;
                        cnt_d         = sat_add(cnt_q, KW_B);
                    end
                end
            end
            ST_TRUNC: begin
                s_tready_c = rdy_en_q;
                if (s_tvalid && rdy_en_q && s_tlast) state_d = ST_PASS;
            end
            default: state_d = ST_PASS;
        endcase
    end

    // State, counters and the registered output stage.
    always_ff @(posedge clk156 or posedge areset_clk156) begin
        if (areset_clk156) begin
            state_q       <= ST_PASS;
            cnt_q         <= '0;
            keep_err_q    <= 1'b0;
            pend_err_q    <= 1'b0;
            rdy_en_q      <= 1'b0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            m_tuser_err_q <= 1'b0;
            m_tdata_q     <= '0;
            m_tkeep_q     <= '0;
            m_tuser_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            keep_err_q    <= keep_err_d;
            pend_err_q    <= pend_err_d;
            rdy_en_q      <= 1'b1;
            m_tvalid_q    <= m_tvalid_d;
            m_tlast_q     <= m_tlast_d;
            m_tuser_err_q <= m_tuser_err_d;
            m_tdata_q     <= m_tdata_d;
            m_tkeep_q     <= m_tkeep_d;
            m_tuser_q     <= m_tuser_d;
        end
    end

    assign s_tready    = s_tready_c;
    assign m_tvalid    = m_tvalid_q;
    assign m_tlast     = m_tlast_q;
    assign m_tuser_err = m_tuser_err_q;
    assign m_tdata     = m_tdata_q;
    assign m_tkeep     = m_tkeep_q;
    assign m_tuser     = m_tuser_q;

`ifdef TX_FRAME_STATS_EN
    logic        tag_pad_q, tag_trunc_q, tag_kerr_q;
    logic [31:0] stat_pad_q, stat_trunc_q, stat_kerr_q;

    // Each output beat carries its frame outcome; counters step on the tlast handshake.
    always_ff @(posedge clk156 or posedge areset_clk156) begin
        if (areset_clk156) begin
            tag_pad_q    <= 1'b0;
            tag_trunc_q  <= 1'b0;
            tag_kerr_q   <= 1'b0;
            stat_pad_q   <= '0;
            stat_trunc_q <= '0;
            stat_kerr_q  <= '0;
        end else begin
            if (load_c) begin
                tag_pad_q   <= tag_pad_c;
                tag_trunc_q <= tag_trunc_c;
                tag_kerr_q  <= tag_kerr_c;
            end
            if (m_tvalid_q && m_tready && m_tlast_q) begin
                if (tag_pad_q)   stat_pad_q   <= stat_pad_q + 32'd1;
                if (tag_trunc_q) stat_trunc_q <= stat_trunc_q + 32'd1;
                if (tag_kerr_q)  stat_kerr_q  <= stat_kerr_q + 32'd1;
            end
        end
    end

    assign stat_pad_pkts      = stat_pad_q;
    assign stat_trunc_pkts    = stat_trunc_q;
    assign stat_keep_err_pkts = stat_kerr_q;
`else
    logic unused_stat_tags;
    assign unused_stat_tags   = load_c ^ tag_pad_c ^ tag_trunc_c ^ tag_kerr_c;
    assign stat_pad_pkts      = '0;
    assign stat_trunc_pkts    = '0;
    assign stat_keep_err_pkts = '0;
`endif
endmodule

// File: tb/tb_tx_frame_conditioner.sv
// Randomised scoreboard bench for tx_frame_conditioner (64-bit data, MIN 60, MAX 250).
module tb_tx_frame_conditioner;
    localparam int MINB = 60;
    localparam int MAXB = 250;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        err;
        logic [7:0]  user;
    } beat_t;

    logic        clk156 = 1'b0;
    logic        areset_clk156 = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic [7:0]  s_tuser = '0;
    logic        s_tuser_err = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep, m_tuser;
    logic        m_tvalid, m_tlast, m_tuser_err;
    logic        m_tready = 1'b0;
    logic [31:0] stat_pad_pkts, stat_trunc_pkts, stat_keep_err_pkts;

    beat_t frm[$];
    beat_t exp_q[$];
    int    n_vec = 0, n_bad = 0;
    int    exp_pad = 0, exp_trunc = 0, exp_kerr = 0;
    bit    rdy_mode = 1'b0;

    tx_frame_conditioner #(
        .AXI_DATA_WIDTH(64), .C_S_AXIS_TUSER_WIDTH(8),
        .MIN_FRAME_BYTES(MINB), .MAX_FRAME_BYTES(MAXB)
    ) dut (
        .clk156(clk156), .areset_clk156(areset_clk156),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tuser_err(s_tuser_err),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tuser_err(m_tuser_err), .m_tready(m_tready),
        .stat_pad_pkts(stat_pad_pkts), .stat_trunc_pkts(stat_trunc_pkts),
        .stat_keep_err_pkts(stat_keep_err_pkts)
    );

    always #5 clk156 = ~clk156;

    initial begin : ready_gen
        forever begin
            @(posedge clk156);
            #1;
            m_tready = rdy_mode ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    function automatic int popc(input logic [7:0] k);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(k[i]);
        return c;
    endfunction

    function automatic logic [7:0] lowmask(input int n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (i < n);
        return m;
    endfunction

    function automatic logic [63:0] bytes_of(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
            n_bad++;
        end
    endtask

    // Frame of len bytes; inject 1 = partial non-last beat, 2 = holey last beat.
    task automatic build_frame(input int len, input int inject);
        int    nb;
        beat_t b;
        nb = (len + 7) / 8;
        frm.delete();
        for (int i = 0; i < nb; i++) begin
            b.data = {$urandom, $urandom};
            b.user = 8'($urandom);
            b.err  = ($urandom_range(0, 7) == 0);
            b.last = (i == nb - 1);
            b.keep = b.last ? lowmask(len - 8 * i) : 8'hFF;
            frm.push_back(b);
        end
        if (inject == 1 && nb > 1) begin
            int idx;
            idx = $urandom_range(0, nb - 2);
            b = frm[idx];
            b.keep = 8'h0F;
            frm[idx] = b;
        end
        if (inject == 2) begin
            b = frm[nb - 1];
            b.keep = 8'hA5;
            frm[nb - 1] = b;
        end
    endtask

    // Expected output of the frame in frm: bytes emitted so far decide padding and truncation.
    task automatic model_frame();
        int    e;
        bit    kerr, pad, trunc, lastb;
        beat_t b, o;
        e = 0; kerr = 0; pad = 0; trunc = 0;
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i];
            lastb = (i == frm.size() - 1);
            if ((!lastb && b.keep != 8'hFF) || (b.keep != lowmask(popc(b.keep)))) kerr = 1;
            o.user = b.user;
            o.data = bytes_of(b.data, b.keep);
            if (e + popc(b.keep) > MAXB) begin
                o.keep = lowmask(MAXB - e); o.last = 1; o.err = 1;
                exp_q.push_back(o);
                trunc = 1;
                break;
            end
            if (lastb && e + popc(b.keep) < MINB) begin
                pad = 1;
                while (e < MINB) begin
                    o.keep = lowmask(MINB - e);
                    o.last = (MINB - e <= 8);
                    o.err  = o.last ? (b.err | kerr) : 1'b0;
                    exp_q.push_back(o);
                    o.data = '0;
                    e += 8;
                end
                break;
            end
            o.keep = b.keep; o.last = lastb;
            o.err  = lastb ? (b.err | kerr) : 1'b0;
            exp_q.push_back(o);
            e += popc(b.keep);
        end
        if (pad)   exp_pad++;
        if (trunc) exp_trunc++;
        if (kerr)  exp_kerr++;
    endtask

    task automatic send_frame();
        int w;
        for (int i = 0; i < frm.size(); i++) begin
            s_tdata = frm[i].data; s_tkeep = frm[i].keep; s_tuser = frm[i].user;
            s_tuser_err = frm[i].err; s_tlast = frm[i].last; s_tvalid = 1'b1;
            w = 0;
            @(negedge clk156);
            while (!s_tready && w < 400) begin
                @(negedge clk156);
                w++;
            end
            if (!s_tready) begin
                $display("FAIL accept_timeout: s_tready %0b after %0d cycles, required 1", s_tready, w);
                n_vec++;
                n_bad++;
            end
            @(posedge clk156);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_frame(input int len, input int inject);
        build_frame(len, inject);
        model_frame();
        send_frame();
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(posedge clk156);
            w++;
        end
        repeat (4) @(posedge clk156);
        #1;
        chk("drain_pending_beats", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_stats();
`ifdef TX_FRAME_STATS_EN
        chk("stat_pad_pkts", stat_pad_pkts, 32'(exp_pad));
        chk("stat_trunc_pkts", stat_trunc_pkts, 32'(exp_trunc));
        chk("stat_keep_err_pkts", stat_keep_err_pkts, 32'(exp_kerr));
`else
        chk("stat_pad_pkts", stat_pad_pkts, 32'd0);
        chk("stat_trunc_pkts", stat_trunc_pkts, 32'd0);
        chk("stat_keep_err_pkts", stat_keep_err_pkts, 32'd0);
`endif
    endtask

    // Monitor: pop and compare on every output handshake; check hold while stalled.
    initial begin : monitor
        beat_t       e;
        bit          stall;
        logic [63:0] hd;
        logic [7:0]  hk, hu;
        logic        hl, he;
        stall = 0; hd = '0; hk = '0; hu = '0; hl = 0; he = 0;
        forever begin
            @(negedge clk156);
            if (areset_clk156) begin
                stall = 0;
            end else begin
                if (stall) begin
                    n_vec++;
                    if (!m_tvalid || m_tdata !== hd || m_tkeep !== hk || m_tlast !== hl ||
                        m_tuser_err !== he || m_tuser !== hu) begin
                        $display("FAIL hold_stable: got v=%0b d=%h k=%h l=%0b e=%0b, held d=%h k=%h l=%0b e=%0b",
                                 m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser_err, hd, hk, hl, he);
                        n_bad++;
                    end
                end
                if (m_tvalid && m_tready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_beat: got d=%h k=%h l=%0b, none expected", m_tdata, m_tkeep, m_tlast);
                        n_bad++;
                    end else begin
                        e = exp_q.pop_front();
                        if (bytes_of(m_tdata, e.keep) !== bytes_of(e.data, e.keep) || m_tkeep !== e.keep ||
                            m_tlast !== e.last || m_tuser_err !== e.err || m_tuser !== e.user) begin
                            $display("FAIL out_beat: got d=%h k=%h l=%0b e=%0b u=%h, expected d=%h k=%h l=%0b e=%0b u=%h",
                                     m_tdata, m_tkeep, m_tlast, m_tuser_err, m_tuser,
                                     e.data, e.keep, e.last, e.err, e.user);
                            n_bad++;
                        end else begin
                            $display("beat ok: d=%h k=%h l=%0b e=%0b", m_tdata, m_tkeep, m_tlast, m_tuser_err);
                        end
                    end
                end
                stall = m_tvalid && !m_tready;
                hd = m_tdata; hk = m_tkeep; hl = m_tlast; he = m_tuser_err; hu = m_tuser;
            end
        end
    end

    initial begin : stim
        int dir_len[$];
        int len, sel;
        dir_len = '{20, 42, 57, 59, 60, 61, 56, 8, 1, 250, 251, 256, 400};

        repeat (3) @(posedge clk156);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tuser_err", 32'(m_tuser_err), 32'd0);
        chk("rst_m_tkeep", 32'(m_tkeep), 32'd0);
        chk("rst_m_tdata", m_tdata[31:0], 32'd0);
        chk("rst_stat_pad", stat_pad_pkts, 32'd0);
        #1 areset_clk156 = 1'b0;
        @(posedge clk156);
        #1;

        foreach (dir_len[i]) run_frame(dir_len[i], 0);
        run_frame(64, 1);
        run_frame(64, 2);
        run_frame(20, 2);
        run_frame(300, 1);

        for (int f = 0; f < 250; f++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      len = $urandom_range(1, 130);
            else if (sel < 9) len = $urandom_range(180, 270);
            else              len = $urandom_range(300, 600);
            run_frame(len, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk156);
                #1;
            end
        end
        drain();
        check_stats();

        // Reset while the block is emitting pad beats.
        rdy_mode = 1'b1;
        repeat (2) @(posedge clk156);
        #1;
        run_frame(5, 0);
        @(posedge clk156);
        #1;
        chk("pad_s_tready_low", 32'(s_tready), 32'd0);
        chk("pad_m_tvalid_high", 32'(m_tvalid), 32'd1);
        @(posedge clk156);
        #2 areset_clk156 = 1'b1;
        #1;
        chk("midpad_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        exp_q.delete();
        exp_pad = 0; exp_trunc = 0; exp_kerr = 0;
        repeat (2) @(posedge clk156);
        #2 areset_clk156 = 1'b0;
        @(posedge clk156);
        #1;
        run_frame(60, 0);
        drain();
        check_stats();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
